seletor_param: RTL

- Parametrised successor of the calculator operation selector.
- Samples N_OPS operation buttons plus an on/off button, synchronises and debounces each one, and detects press edges.
- Runs a power/selection state machine that drives a one-hot operation select.
- Captures operand magnitudes and signs at selection time, so the downstream calculator sees stable operands and a one-cycle "new operation" strobe.

---
 rtl/seletor_param_if.sv | 49 ++++
 rtl/seletor_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seletor_param_if.sv
// -----------------------------------------------------------------------------
// seletor_param_if
//
// Button/operand bundle between the calculator front panel and the operation
// selector.
//
//   botoes       panel -> selector  raw operation buttons (bit 0 mult, 1 soma,
//                                   2 subt, ...), active-high, asynchronous
//   botao_onoff  panel -> selector  raw on/off button, active-high, async
//   a, b         panel -> selector  operand magnitudes
//   sinal_a/b    panel -> selector  operand signs
//   ligado       selector -> calc   unit is on
//   sel          selector -> calc   one-hot selected operation (0 when none/off)
//   sel_valid    selector -> calc   one-cycle strobe when sel/operands reload
//   op_a, op_b   selector -> calc   captured operand magnitudes
//   sinal_op_a/b selector -> calc   captured operand signs
//
// The master modport is the side that drives the buttons and operands; the
// slave modport is the selector itself.
// -----------------------------------------------------------------------------
interface seletor_param_if #(
  parameter int N_OPS = 3,
  parameter int W     = 8
);
  logic [N_OPS-1:0] botoes;
  logic             botao_onoff;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sinal_a;
  logic             sinal_b;

  logic             ligado;
  logic [N_OPS-1:0] sel;
  logic             sel_valid;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             sinal_op_a;
  logic             sinal_op_b;

  modport master (
    output botoes, botao_onoff, a, b, sinal_a, sinal_b,
    input  ligado, sel, sel_valid, op_a, op_b, sinal_op_a, sinal_op_b
  );

  modport slave (
    input  botoes, botao_onoff, a, b, sinal_a, sinal_b,
    output ligado, sel, sel_valid, op_a, op_b, sinal_op_a, sinal_op_b
  );
endinterface

// File: rtl/seletor_param.sv
// -----------------------------------------------------------------------------
// seletor_param
//
// Parametrised calculator operation selector. Each of the N_OPS operation
// buttons and the on/off button goes through a 2-flop synchroniser, a
// consecutive-sample debouncer and a rising-edge detector. A small power /
// selection state machine (DESLIGADO, IDLE, ATIVO) turns the resulting press
// pulses into a one-hot operation select, and freezes the operands present in
// the detection cycle so the downstream calculator sees stable inputs plus a
// one-cycle sel_valid strobe.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   io   seletor_param_if.slave: botoes, botao_onoff, a, b, sinal_a, sinal_b
//        in; ligado, sel, sel_valid, op_a, op_b, sinal_op_a, sinal_op_b out
//
// Parameters:
//   N_OPS           number of operation buttons / width of sel (1..8)
//   W               operand magnitude width
//   DEB_CYCLES      consecutive synchronised samples a new level must hold
//   TIMEOUT_CYCLES  idle cycles before automatic power-off
//
// Build option:
//   SELETOR_AUTO_OFF_EN  when defined, the unit switches itself off after
//                        TIMEOUT_CYCLES cycles without any debounced press.
//                        When undefined the unit stays on until an on/off
//                        press or reset, and TIMEOUT_CYCLES has no effect.
//
// Latency: a raw level first sampled at edge k (and held) becomes the
// debounced level at edge k+1+DEB_CYCLES; the selection outputs react at
// edge k+2+DEB_CYCLES.
// -----------------------------------------------------------------------------
module seletor_param #(
  parameter int N_OPS          = 3,
  parameter int W              = 8,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  seletor_param_if.slave io
);

  // The on/off button is handled as one more lane above the operation buttons.
  localparam int L     = N_OPS + 1;
  localparam int ONOFF = N_OPS;
  localparam int CW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    IDLE      = 2'd1,
    ATIVO     = 2'd2
  } state_t;

  // Isolates the lowest set request bit: req & -req.
  function automatic logic [N_OPS-1:0] lowest_onehot(input logic [N_OPS-1:0] req);
    return req & (~req + N_OPS'(1));
  endfunction

  logic [L-1:0]         raw;
  logic [L-1:0]         s1_p0;
  logic [L-1:0]         s2_p1;
  logic [L-1:0]         deb_p2;
  logic [L-1:0]         deb_prev_p3;
  logic [L-1:0][CW-1:0] cnt;
  logic [L-1:0]         press;
  logic [N_OPS-1:0]     op_press;
  logic                 timeout_hit;

  state_t               state;
  state_t               state_nx;
  logic                 load_op;
  logic                 clear_op;
  logic [N_OPS-1:0]     sel_nx;

  logic [N_OPS-1:0]     sel_q;
  logic                 sel_valid_q;
  logic [W-1:0]         op_a_q;
  logic [W-1:0]         op_b_q;
  logic                 sinal_op_a_q;
  logic                 sinal_op_b_q;

  assign raw = {io.botao_onoff, io.botoes};

  // Stage p0/p1: two-flop synchroniser. Stage p2: debounced level.
  // Debounced levels reset high so a button held through reset must be
  // released and pressed again before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0       <= '0;
      s2_p1       <= '0;
      deb_p2      <= '1;
      deb_prev_p3 <= '1;
      cnt         <= '0;
    end else begin
      s1_p0       <= raw;
      s2_p1       <= s1_p0;
      deb_prev_p3 <= deb_p2;
      for (int i = 0; i < L; i++) begin
        if (s2_p1[i] == deb_p2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // This edge sees the DEB_CYCLES-th consecutive disagreement.
          deb_p2[i] <= s2_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Stage p3: rising edge of the debounced level is a press.
  assign press    = deb_p2 & ~deb_prev_p3;
  assign op_press = press[N_OPS-1:0];

`ifdef SELETOR_AUTO_OFF_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] idle_cnt;

  // Counts cycles spent on without any debounced press.
  always_ff @(posedge clk) begin
    if (rst || (state == DESLIGADO) || (|press)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DESLIGADO;
    end else begin
      state <= state_nx;
    end
  end

  // Priority while on: on/off press, then lowest-index operation press, then
  // the idle timeout (so any press cancels a coincident timeout).
  always_comb begin
    state_nx = state;
    load_op  = 1'b0;
    clear_op = 1'b0;
    sel_nx   = lowest_onehot(op_press);
    case (state)
      DESLIGADO: begin
        if (press[ONOFF]) begin
          state_nx = IDLE;
        end
      end
      default: begin
        if (press[ONOFF]) begin
          state_nx = DESLIGADO;
          clear_op = 1'b1;
        end else if (|op_press) begin
          state_nx = ATIVO;
          load_op  = 1'b1;
        end else if (timeout_hit) begin
          state_nx = DESLIGADO;
          clear_op = 1'b1;
        end
      end
    endcase
  end

  // Stage p4: selection and operand capture registers. Operands only move on
  // a load or on power-off, never in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sinal_op_a_q <= 1'b0;
      sinal_op_b_q <= 1'b0;
    end else begin
      sel_valid_q <= load_op;
      if (clear_op) begin
        sel_q        <= '0;
        op_a_q       <= '0;
        op_b_q       <= '0;
        sinal_op_a_q <= 1'b0;
        sinal_op_b_q <= 1'b0;
      end else if (load_op) begin
        sel_q        <= sel_nx;
        op_a_q       <= io.a;
        op_b_q       <= io.b;
        sinal_op_a_q <= io.sinal_a;
        sinal_op_b_q <= io.sinal_b;
      end
    end
  end

  assign io.ligado     = (state != DESLIGADO);
  assign io.sel        = sel_q;
  assign io.sel_valid  = sel_valid_q;
  assign io.op_a       = op_a_q;
  assign io.op_b       = op_b_q;
  assign io.sinal_op_a = sinal_op_a_q;
  assign io.sinal_op_b = sinal_op_b_q;

endmodule
